// File: rtl/nes_router_debounce.sv
// nes_router_debounce: routes NES button codes to the selected device's code window,
// debounces each press and emits press / auto-repeat / release strobes.
module nes_router_debounce #(
    parameter int NUM_DEV       = 3,
    parameter int BTN_PER_DEV   = 4,
    parameter int CODE_W        = 5,
    parameter int STATE_W       = 4,
    parameter int BASE_ROT      = 1,
    parameter int STABLE_CYCLES = 3,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [CODE_W-1:0]  nes_in_i,
    input  logic [STATE_W-1:0] state_i,
    output logic [CODE_W-1:0]  nes_out_o,
    output logic               btn_valid_o,
    output logic               press_pulse_o,
    output logic               repeat_pulse_o,
    output logic               release_pulse_o
);
    localparam int IDLE_CODE = NUM_DEV * BTN_PER_DEV;
    localparam int MAX_SR    = STABLE_CYCLES > REPEAT_DELAY ? STABLE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT   = MAX_SR > REPEAT_PERIOD ? MAX_SR : REPEAT_PERIOD;
    localparam int CW        = $clog2(MAX_CNT + 1);
    localparam logic [CODE_W-1:0] IDLE_C = CODE_W'(IDLE_CODE);

    typedef enum logic [1:0] {IDLE, QUAL, HELD} st_t;

    st_t               st_q, st_d;
    logic [CODE_W-1:0]  in_q, cand_q, cand_d, nes_out_q, nes_out_d;
    logic [STATE_W-1:0] state_q, sprev_q;
    logic [CW-1:0]      cnt_q, cnt_d, rcnt_q, rcnt_d;
    logic               valid_q, valid_d, press_q, press_d, rep_q, rep_d, rel_q, rel_d;
    logic               win, brk;

    // Codes at or above IDLE_CODE fall past every window, so they read as idle.
    function automatic logic in_win(input logic [STATE_W-1:0] s, input logic [CODE_W-1:0] c);
        int b;
        b = ((int'(s) + BASE_ROT) % NUM_DEV) * BTN_PER_DEV;
        return (int'(s) < NUM_DEV) && (int'(c) >= b) && (int'(c) < b + BTN_PER_DEV);
    endfunction

    always_comb begin
        win     = in_win(state_q, in_q);
        brk     = (state_q != sprev_q) || (in_q != cand_q) || !win;
        st_d    = st_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        press_d = 1'b0;
        rep_d   = 1'b0;
        rel_d   = 1'b0;
        case (st_q)
            IDLE: if (win) begin
                cand_d = in_q;
                cnt_d  = CW'(1);
                st_d   = STABLE_CYCLES == 1 ? HELD : QUAL;
            end
            QUAL: if (brk) begin
                st_d  = IDLE;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                st_d  = cnt_d == CW'(STABLE_CYCLES) ? HELD : QUAL;
            end
            HELD: if (brk) begin
                st_d   = IDLE;
                rel_d  = 1'b1;
                rcnt_d = '0;
            end else begin
                rep_d  = (rcnt_q == CW'(1)) && (REPEAT_EN != 0);
                rcnt_d = rcnt_q == CW'(1) ? CW'(REPEAT_PERIOD) : rcnt_q - 1'b1;
            end
            default: st_d = IDLE;
        endcase
        if (st_d == HELD && st_q != HELD) begin
            press_d = 1'b1;
            rcnt_d  = CW'(REPEAT_DELAY);
        end
        nes_out_d = st_d == HELD ? cand_d : IDLE_C;
        valid_d   = st_d == HELD;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            st_q      <= IDLE;
            in_q      <= IDLE_C;
            state_q   <= '0;
            sprev_q   <= '0;
            cand_q    <= IDLE_C;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            nes_out_q <= IDLE_C;
            valid_q   <= 1'b0;
            press_q   <= 1'b0;
            rep_q     <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            in_q      <= nes_in_i;
            state_q   <= state_i;
            sprev_q   <= state_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            nes_out_q <= nes_out_d;
            valid_q   <= valid_d;
            press_q   <= press_d;
            rep_q     <= rep_d;
            rel_q     <= rel_d;
        end
    end

    assign nes_out_o       = nes_out_q;
    assign btn_valid_o     = valid_q;
    assign press_pulse_o   = press_q;
    assign repeat_pulse_o  = rep_q;
    assign release_pulse_o = rel_q;
endmodule

// File: tb/tb_nes_router_debounce.sv
// tb_nes_router_debounce: random and directed stimulus against a run-length model,
// with two DUTs (auto-repeat on and off) sharing the same inputs.
module tb_nes_router_debounce;
    localparam int N = 3, BPD = 4, ROT = 1, S = 3, D = 8, P = 4;
    localparam int IDLE = N * BPD;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] nes_in;
    logic [3:0] state;
    logic [4:0] out_a, out_b;
    logic       val_a, val_b, prs_a, prs_b, rep_a, rep_b, rel_a, rel_b;

    int n_chk = 0, n_fail = 0;
    bit started = 0;

    int m_iq, m_sq, m_sprev, m_code, m_age;
    int e_out;
    bit e_val, e_prs, e_rep, e_rel;

    always #5 clk = ~clk;

    nes_router_debounce u_a (
        .clk_i(clk), .reset_n_i(reset_n), .nes_in_i(nes_in), .state_i(state),
        .nes_out_o(out_a), .btn_valid_o(val_a), .press_pulse_o(prs_a),
        .repeat_pulse_o(rep_a), .release_pulse_o(rel_a)
    );

    nes_router_debounce #(.REPEAT_EN(0)) u_b (
        .clk_i(clk), .reset_n_i(reset_n), .nes_in_i(nes_in), .state_i(state),
        .nes_out_o(out_b), .btn_valid_o(val_b), .press_pulse_o(prs_b),
        .repeat_pulse_o(rep_b), .release_pulse_o(rel_b)
    );

    // Ownership view: a code belongs to the one device whose rotated window contains it.
    function automatic bit m_win(int s, int c);
        if (s >= N || c >= IDLE) return 1'b0;
        return ((c / BPD - ROT % N + N) % N) == s;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // m_age counts consecutive edges the same in-window code has survived; held once it reaches S.
    always @(posedge clk) begin
        started = 1;
        e_prs = 0; e_rep = 0; e_rel = 0;
        if (!reset_n) begin
            m_iq = IDLE; m_sq = 0; m_sprev = 0; m_age = 0; m_code = IDLE;
        end else begin
            if (m_age > 0 && (m_sq != m_sprev || m_iq != m_code || !m_win(m_sq, m_iq))) begin
                e_rel = m_age >= S;
                m_age = 0;
            end else if (m_age == 0) begin
                if (m_win(m_sq, m_iq)) begin m_code = m_iq; m_age = 1; end
            end else m_age++;
            e_prs = m_age == S;
            e_rep = m_age > S && (m_age - S) >= D && ((m_age - S - D) % P) == 0;
            m_sprev = m_sq; m_sq = int'(state); m_iq = int'(nes_in);
        end
        e_val = m_age >= S;
        e_out = e_val ? m_code : IDLE;
    end

    always @(negedge clk) if (started) begin
        check("nes_out_a", 32'(out_a), 32'(e_out));
        check("btn_valid_a", 32'(val_a), 32'(e_val));
        check("press_a", 32'(prs_a), 32'(e_prs));
        check("repeat_a", 32'(rep_a), 32'(e_rep));
        check("release_a", 32'(rel_a), 32'(e_rel));
        check("nes_out_b", 32'(out_b), 32'(e_out));
        check("btn_valid_b", 32'(val_b), 32'(e_val));
        check("press_b", 32'(prs_b), 32'(e_prs));
        check("repeat_b", 32'(rep_b), 32'(0));
        check("release_b", 32'(rel_b), 32'(e_rel));
    end

    task automatic drive(input int c, input int s, input int n);
        nes_in = 5'(c);
        state = 4'(s);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        reset_n = 0; nes_in = 5; state = 0;
        repeat (2) begin @(posedge clk); #1; end
        check("lit_reset_out", 32'(out_a), 12);
        check("lit_reset_valid", 32'(val_a), 0);
        check("lit_reset_pulses", 32'({prs_a, rep_a, rel_a}), 0);
        reset_n = 1;
        drive(5, 0, 3);
        check("lit_pre_accept", 32'(out_a), 12);
        drive(5, 0, 1);
        check("lit_accept_out", 32'(out_a), 5);
        check("lit_accept_press", 32'(prs_a), 1);
        drive(5, 0, 7);
        check("lit_no_early_repeat", 32'(rep_a), 0);
        drive(5, 0, 1);
        check("lit_first_repeat", 32'(rep_a), 1);
        check("lit_repeat_disabled", 32'(rep_b), 0);
        drive(12, 0, 1);
        check("lit_still_held", 32'(val_a), 1);
        drive(12, 0, 1);
        check("lit_release", 32'(rel_a), 1);
        check("lit_release_out", 32'(out_a), 12);
        for (int i = 0; i < 6; i++) drive(i % 2 ? 6 : 5, 0, 1);
        check("lit_toggle_rejected", 32'(val_a), 0);
        drive(5, 0, 2); drive(12, 0, 3);
        check("lit_short_rejected", 32'(val_a), 0);
        drive(2, 0, 5);
        check("lit_wrong_window", 32'(out_a), 12);
        drive(2, 2, 4);
        check("lit_window_s2", 32'(out_a), 2);
        drive(10, 1, 5);
        check("lit_window_s1", 32'(out_a), 10);
        drive(10, 0, 1);
        check("lit_state_chg_held", 32'(val_a), 1);
        drive(10, 0, 1);
        check("lit_state_chg_release", 32'(rel_a), 1);
        drive(10, 0, 5);
        check("lit_no_reaccept", 32'(out_a), 12);
        drive(3, 3, 6);
        check("lit_state3_none", 32'(out_a), 12);
        drive(7, 0, 4);
        check("lit_held_7", 32'(out_a), 7);
        reset_n = 0;
        drive(7, 0, 1);
        check("lit_midpress_reset_out", 32'(out_a), 12);
        check("lit_midpress_reset_rel", 32'(rel_a), 0);
        reset_n = 1;
        for (int seg = 0; seg < 400; seg++) begin
            int s, c, k;
            s = $urandom_range(0, 9) < 8 ? $urandom_range(0, 2) : $urandom_range(3, 15);
            k = $urandom_range(0, 9);
            c = k < 6 ? ((s + ROT) % N) * BPD + $urandom_range(0, BPD - 1)
              : k < 8 ? $urandom_range(0, 31) : IDLE;
            if ($urandom_range(0, 49) == 0) reset_n = 0;
            drive(c & 31, s, $urandom_range(1, 18));
            reset_n = 1;
        end
        drive(IDLE, 0, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
